// File: rtl/uart_engine_pkg.sv
// uart_engine_pkg: shared FSM states, mode constants and counter-width helper for the UART operand engine
package uart_engine_pkg;
   typedef enum logic {S_RX, S_TX} state_t;
   localparam int MODE_SUM = 0;
   localparam int MODE_DOT = 1;
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/uart_operand_assembler.sv
// uart_operand_assembler: gathers OPERAND_BYTES little-endian bytes and presents the operand on its final byte
module uart_operand_assembler
   import uart_engine_pkg::*;
#(
   parameter int OPERAND_BYTES = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       in_valid,
   input  logic [7:0]                 in_data,
   output logic [8*OPERAND_BYTES-1:0] operand,
   output logic                       operand_valid
);
   localparam int BW = cnt_w(OPERAND_BYTES);
   logic [BW-1:0] byte_idx;
   logic [8*OPERAND_BYTES-1:0] shreg;
   assign operand_valid = in_valid && byte_idx == BW'(OPERAND_BYTES - 1);
   always_comb begin
      operand = shreg;
      operand[8*byte_idx +: 8] = in_data;
   end
   always_ff @(posedge clk)
      if (rst || clear) begin
         byte_idx <= '0;
         shreg <= '0;
      end else if (in_valid) begin
         shreg[8*byte_idx +: 8] <= in_data;
         byte_idx <= operand_valid ? '0 : byte_idx + 1'b1;
      end
endmodule

// File: rtl/uart_operand_engine.sv
// uart_operand_engine: UART byte-stream sum/dot-product engine; optional inter-byte timeout via UART_ENGINE_TIMEOUT_EN
module uart_operand_engine
   import uart_engine_pkg::*;
#(
   parameter int OPERAND_BYTES  = 1,
   parameter int NUM_OPERANDS   = 2,
   parameter int RESULT_BYTES   = 1,
   parameter int MODE           = 0,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   input  logic       rx_err,
   output logic       tx_valid,
   output logic [7:0] tx_data,
   input  logic       tx_ready,
   output logic [7:0] led,
   output logic       busy,
   output logic       done,
   output logic       frame_err,
   output logic       overrun
);
   localparam int ACC_W = 8 * RESULT_BYTES;
   localparam int OW    = 8 * OPERAND_BYTES;
   localparam int NW    = cnt_w(NUM_OPERANDS);
   localparam int TW    = cnt_w(RESULT_BYTES);
   if (OPERAND_BYTES < 1 || OPERAND_BYTES > 4 || NUM_OPERANDS < 2 || TIMEOUT_CYCLES < 1 ||
       (MODE == MODE_DOT && NUM_OPERANDS % 2 != 0)) begin : g_bad_cfg
      $error("uart_operand_engine: unsupported parameter combination");
   end
   state_t state, state_nxt;
   logic [ACC_W-1:0] acc, acc_nxt, prod, contrib;
   logic [OW-1:0] hold, operand;
   logic [NW-1:0] op_cnt;
   logic [TW-1:0] tx_idx;
   logic accept, rx_bad, discard, timeout, operand_valid, last_op, frame_end, tx_fire, tx_last;
   assign accept    = state == S_RX && rx_valid && !rx_err;
   assign rx_bad    = state == S_RX && rx_valid && rx_err;
   assign discard   = rx_bad || timeout;
   assign last_op   = op_cnt == NW'(NUM_OPERANDS - 1);
   assign frame_end = operand_valid && last_op;
   assign tx_valid  = state == S_TX;
   assign busy      = state == S_TX;
   assign tx_data   = tx_valid ? acc[8*tx_idx +: 8] : 8'h00;
   assign tx_fire   = tx_valid && tx_ready;
   assign tx_last   = tx_fire && tx_idx == TW'(RESULT_BYTES - 1);
   // products are formed at accumulator width, so overflow wraps modulo 2^ACC_W
   assign prod      = ACC_W'(hold) * ACC_W'(operand);
   assign contrib   = MODE == MODE_DOT ? (op_cnt[0] ? prod : '0) : ACC_W'(operand);
   assign acc_nxt   = acc + contrib;
   uart_operand_assembler #(.OPERAND_BYTES(OPERAND_BYTES)) u_asm (
      .clk(clk),
      .rst(rst),
      .clear(discard || frame_end),
      .in_valid(accept),
      .in_data(rx_data),
      .operand(operand),
      .operand_valid(operand_valid)
   );
`ifdef UART_ENGINE_TIMEOUT_EN
   localparam int TOW = cnt_w(TIMEOUT_CYCLES);
   logic pending;
   logic [TOW-1:0] to_cnt;
   // a byte arriving on the expiry cycle wins over the timeout
   assign timeout = pending && !rx_valid && to_cnt == TOW'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge clk)
      if (rst || discard || frame_end) begin
         pending <= 1'b0;
         to_cnt <= '0;
      end else if (accept) begin
         pending <= 1'b1;
         to_cnt <= '0;
      end else if (pending) begin
         to_cnt <= to_cnt + 1'b1;
      end
`else
   assign timeout = 1'b0;
`endif
   always_ff @(posedge clk)
      state <= rst ? S_RX : state_nxt;
   always_comb
      state_nxt = (state == S_RX && frame_end) ? S_TX : tx_last ? S_RX : state;
   always_ff @(posedge clk)
      if (rst) begin
         acc <= '0;
         hold <= '0;
         op_cnt <= '0;
         tx_idx <= '0;
         led <= '0;
         done <= 1'b0;
         frame_err <= 1'b0;
         overrun <= 1'b0;
      end else begin
         done <= tx_last;
         frame_err <= discard;
         overrun <= state == S_TX && rx_valid;
         if (discard || tx_last) begin
            acc <= '0;
            hold <= '0;
            op_cnt <= '0;
         end else if (operand_valid) begin
            acc <= acc_nxt;
            if (MODE == MODE_DOT && !op_cnt[0]) hold <= operand;
            op_cnt <= last_op ? '0 : op_cnt + 1'b1;
         end
         if (accept) led <= frame_end ? acc_nxt[7:0] : rx_data;
         if (frame_end) tx_idx <= '0;
         else if (tx_fire) tx_idx <= tx_idx + 1'b1;
      end
endmodule

// File: tb/tb_uart_operand_engine.sv
// tb_uart_operand_engine: directed checks of sum, wide-operand and dot-product engine builds
module tb_uart_operand_engine;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rv[3], re[3], tv[3], tr[3], bz[3], dn[3], fe[3], ov[3];
   logic [7:0] rd[3], td[3], ld[3];
   int done_cnt[3], fe_cnt[3], ov_cnt[3];
   int errors = 0;
   int checks = 0;
   always #5 clk = ~clk;
   uart_operand_engine #(.TIMEOUT_CYCLES(50)) u_sum (
      .clk(clk), .rst(rst), .rx_valid(rv[0]), .rx_data(rd[0]), .rx_err(re[0]),
      .tx_valid(tv[0]), .tx_data(td[0]), .tx_ready(tr[0]), .led(ld[0]), .busy(bz[0]),
      .done(dn[0]), .frame_err(fe[0]), .overrun(ov[0]));
   uart_operand_engine #(.OPERAND_BYTES(2), .RESULT_BYTES(3), .TIMEOUT_CYCLES(50)) u_wide (
      .clk(clk), .rst(rst), .rx_valid(rv[1]), .rx_data(rd[1]), .rx_err(re[1]),
      .tx_valid(tv[1]), .tx_data(td[1]), .tx_ready(tr[1]), .led(ld[1]), .busy(bz[1]),
      .done(dn[1]), .frame_err(fe[1]), .overrun(ov[1]));
   uart_operand_engine #(.NUM_OPERANDS(4), .RESULT_BYTES(2), .MODE(1), .TIMEOUT_CYCLES(50)) u_dot (
      .clk(clk), .rst(rst), .rx_valid(rv[2]), .rx_data(rd[2]), .rx_err(re[2]),
      .tx_valid(tv[2]), .tx_data(td[2]), .tx_ready(tr[2]), .led(ld[2]), .busy(bz[2]),
      .done(dn[2]), .frame_err(fe[2]), .overrun(ov[2]));
   // pulses are counted on the edge that ends the cycle they are visible in
   always @(posedge clk)
      for (int k = 0; k < 3; k++) begin
         done_cnt[k] <= done_cnt[k] + int'(dn[k]);
         fe_cnt[k] <= fe_cnt[k] + int'(fe[k]);
         ov_cnt[k] <= ov_cnt[k] + int'(ov[k]);
      end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic send(input int k, input logic [7:0] d, input logic e);
      rv[k] = 1'b1;
      rd[k] = d;
      re[k] = e;
      @(negedge clk);
      rv[k] = 1'b0;
      re[k] = 1'b0;
   endtask
   task automatic get_byte(input int k, input logic [7:0] exp, input string tag);
      int n = 0;
      while (!tv[k] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_valid"}, 32'(tv[k]), 32'd1);
      chk(tag, 32'(td[k]), 32'(exp));
      tr[k] = 1'b1;
      @(negedge clk);
      tr[k] = 1'b0;
   endtask
   initial begin
      for (int k = 0; k < 3; k++) begin
         rv[k] = 1'b0; re[k] = 1'b0; rd[k] = 8'h00; tr[k] = 1'b0;
         done_cnt[k] = 0; fe_cnt[k] = 0; ov_cnt[k] = 0;
      end
      idle(3);
      chk("rst_tx_valid", 32'(tv[0]), 32'd0);
      chk("rst_tx_data", 32'(td[0]), 32'd0);
      chk("rst_led", 32'(ld[0]), 32'd0);
      chk("rst_busy", 32'(bz[0]), 32'd0);
      chk("rst_flags", {29'd0, dn[0], fe[0], ov[0]}, 32'd0);
      rst = 1'b0;
      idle(1);
      send(0, 8'h05, 1'b0);
      chk("sum_led_byte", 32'(ld[0]), 32'h05);
      chk("sum_busy_mid", 32'(bz[0]), 32'd0);
      send(0, 8'h07, 1'b0);
      chk("sum_latency", 32'(tv[0]), 32'd1);
      chk("sum_busy", 32'(bz[0]), 32'd1);
      chk("sum_led_result", 32'(ld[0]), 32'h0C);
      get_byte(0, 8'h0C, "sum_tx");
      chk("sum_done_now", 32'(dn[0]), 32'd1);
      chk("sum_back_rx", 32'(tv[0]), 32'd0);
      idle(2);
      chk("sum_done_once", 32'(done_cnt[0]), 32'd1);
      send(0, 8'hF0, 1'b0);
      send(0, 8'h20, 1'b0);
      get_byte(0, 8'h10, "wrap_tx");
      send(0, 8'h09, 1'b0);
      send(0, 8'hAA, 1'b1);
      idle(2);
      chk("err_frame_err", 32'(fe_cnt[0]), 32'd1);
      chk("err_no_tx", 32'(tv[0]), 32'd0);
      send(0, 8'h01, 1'b0);
      send(0, 8'h02, 1'b0);
      chk("err_recover_led", 32'(ld[0]), 32'h03);
      send(0, 8'h55, 1'b0);
      idle(1);
      chk("ovr_pulse", 32'(ov_cnt[0]), 32'd1);
      chk("ovr_tx_data", 32'(td[0]), 32'h03);
      get_byte(0, 8'h03, "ovr_tx");
      idle(2);
      chk("ovr_done_cnt", 32'(done_cnt[0]), 32'd3);
      send(1, 8'hFF, 1'b0);
      send(1, 8'hFF, 1'b0);
      send(1, 8'h01, 1'b0);
      chk("wide_mid", 32'(tv[1]), 32'd0);
      send(1, 8'h00, 1'b0);
      chk("wide_led", 32'(ld[1]), 32'h00);
      get_byte(1, 8'h00, "wide_b0");
      get_byte(1, 8'h00, "wide_b1");
      get_byte(1, 8'h01, "wide_b2");
      idle(2);
      chk("wide_done", 32'(done_cnt[1]), 32'd1);
      send(2, 8'd3, 1'b0);
      send(2, 8'd4, 1'b0);
      send(2, 8'd5, 1'b0);
      send(2, 8'd6, 1'b0);
      chk("dot_led", 32'(ld[2]), 32'h2A);
      for (int i = 0; i < 5; i++) begin
         chk("dot_stall_data", 32'(td[2]), 32'h2A);
         chk("dot_stall_valid", 32'(tv[2]), 32'd1);
         idle(1);
      end
      get_byte(2, 8'h2A, "dot_b0");
      get_byte(2, 8'h00, "dot_b1");
      idle(2);
      chk("dot_done", 32'(done_cnt[2]), 32'd1);
      send(2, 8'd1, 1'b0);
      send(2, 8'd1, 1'b0);
      send(2, 8'd1, 1'b0);
      send(2, 8'd1, 1'b0);
      chk("rst_tx_busy", 32'(bz[2]), 32'd1);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      chk("rst_tx_abort", 32'(tv[2]), 32'd0);
      idle(2);
      chk("rst_tx_no_done", 32'(done_cnt[2]), 32'd1);
      send(2, 8'd2, 1'b0);
      send(2, 8'd3, 1'b0);
      send(2, 8'd4, 1'b0);
      send(2, 8'd1, 1'b0);
      get_byte(2, 8'h0A, "dot_fresh_b0");
      get_byte(2, 8'h00, "dot_fresh_b1");
      send(0, 8'h09, 1'b0);
      idle(60);
`ifdef UART_ENGINE_TIMEOUT_EN
      chk("to_frame_err", 32'(fe_cnt[0]), 32'd2);
      send(0, 8'h01, 1'b0);
      send(0, 8'h02, 1'b0);
      get_byte(0, 8'h03, "to_tx");
`else
      chk("to_no_frame_err", 32'(fe_cnt[0]), 32'd1);
      send(0, 8'h01, 1'b0);
      get_byte(0, 8'h0A, "to_tx");
`endif
      send(0, 8'h04, 1'b0);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      send(0, 8'h04, 1'b0);
      send(0, 8'h05, 1'b0);
      get_byte(0, 8'h09, "rst_mid_frame_tx");
      idle(2);
      chk("no_spurious_ovr", 32'(ov_cnt[0] + ov_cnt[1] + ov_cnt[2]), 32'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
